// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the boot loader.
// master = stream source / memory side, slave = the loader itself.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses header / little-endian words / checksum from a byte
// stream, writes words to program memory from address 0, releases CPU reset.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  xfer;
    logic [15:0]           n_full;

    assign xfer   = bus.byte_valid && byte_ready_q;
    assign n_full = {bus.byte_in, cnt_q[7:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_HDR0: if (xfer) begin
                cnt_d[7:0] = bus.byte_in;
                state_d    = S_HDR1;
            end
            S_HDR1: if (xfer) begin
                cnt_d = n_full;
                if ({1'b0, n_full} > MAX_W)
                    state_d = S_ERROR;
                else if (n_full == 16'd0)
                    state_d = S_CHECK;
                else
                    state_d = S_DATA;
            end
            S_DATA: if (xfer) begin
                // Only three bytes are buffered; the fourth goes straight out.
                asm_d      = {bus.byte_in, asm_q[23:8]};
                csum_d     = csum_q + bus.byte_in;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = {bus.byte_in, asm_q};
                    word_cnt_d  = word_cnt_q + 16'd1;
                    if (word_cnt_q == cnt_q - 16'd1)
                        state_d = S_CHECK;
                end
            end
            S_CHECK: if (xfer) begin
                state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = state_q;
        endcase

        // Status outputs are registered from the next state, so they change
        // in the cycle right after the deciding byte is accepted.
        byte_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
        cpu_reset_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_HDR0;
            cnt_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule
